dht11_read_scheduler: RTL and testbench

DHT11_READ_SCHEDULER -- requirements
Module: dht11_read_scheduler

---
 rtl/dht11_sched_pkg.sv | 63 ++++++
 rtl/dht11_guard_timer.sv | 28 ++
 rtl/dht11_read_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_dht11_read_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_sched_pkg.sv
// Shared command/response codes, FSM state encoding and small helpers
// for the DHT11 read scheduler.
package dht11_sched_pkg;

    localparam logic [3:0] CMD_STATUS    = 4'h0;
    localparam logic [3:0] CMD_TEMP      = 4'h1;
    localparam logic [3:0] CMD_HUM       = 4'h2;
    localparam logic [3:0] CMD_CONT_TEMP = 4'h3;
    localparam logic [3:0] CMD_CONT_HUM  = 4'h4;
    localparam logic [3:0] CMD_STOP      = 4'h5;

    localparam logic [7:0] RSP_OK        = 8'h07;
    localparam logic [7:0] RSP_HUM       = 8'h08;
    localparam logic [7:0] RSP_TEMP      = 8'h09;
    localparam logic [7:0] RSP_STOPPED   = 8'h0A;
    localparam logic [7:0] RSP_FAULT     = 8'h1F;
    localparam logic [7:0] RSP_INVALID   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_LOW,
        ST_READ,
        ST_EVAL,
        ST_RESP,
        ST_CONT_WAIT
    } state_t;

    typedef enum logic [1:0] {
        KIND_STATUS,
        KIND_TEMP,
        KIND_HUM
    } kind_t;

    // Bits needed to hold values 0..max_val (at least one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic cmd_needs_read(input logic [3:0] code);
        return code <= CMD_CONT_HUM;
    endfunction

    function automatic logic cmd_is_cont(input logic [3:0] code);
        return (code == CMD_CONT_TEMP) || (code == CMD_CONT_HUM);
    endfunction

    function automatic kind_t cmd_kind(input logic [3:0] code);
        case (code)
            CMD_TEMP, CMD_CONT_TEMP: return KIND_TEMP;
            CMD_HUM, CMD_CONT_HUM:   return KIND_HUM;
            default:                 return KIND_STATUS;
        endcase
    endfunction

    // Checksum byte must equal the 8-bit wrapped sum of the four data bytes.
    function automatic logic checksum_ok(input logic [39:0] d);
        logic [7:0] sum;
        sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
        return sum == d[7:0];
    endfunction

endpackage

// File: rtl/dht11_guard_timer.sv
// Saturating cycle counter enforcing the minimum rest time between sensor reads.
module dht11_guard_timer
    import dht11_sched_pkg::*;
#(
    parameter int GUARD_CYCLES = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int              GW    = cnt_width(GUARD_CYCLES);
    localparam logic [GW-1:0]   LIMIT = GW'(GUARD_CYCLES);

    logic [GW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count < LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/dht11_read_scheduler.sv
// Command-driven scheduler for DHT11 reads: enforces the guard interval, pulses
// the sensor enable, checks the result and returns one response per command.
module dht11_read_scheduler
    import dht11_sched_pkg::*;
#(
    parameter int GUARD_CYCLES   = 100_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int LOW_CYCLES     = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_code,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_code,
    output logic [7:0]  resp_data,
    output logic        sensor_enable,
    input  logic [39:0] sensor_data,
    input  logic        sensor_error,
    input  logic        sensor_done,
    output state_t      state_dbg
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; a raised resp_valid holds code and data until that edge.

    localparam int            TW       = cnt_width(TIMEOUT_CYCLES);
    localparam int            LW       = cnt_width(LOW_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOW_LAST = LW'(LOW_CYCLES - 1);

    state_t        state;
    kind_t         kind;
    logic          cont_mode;
    logic          timed_out;
    logic          err_q;
    logic [39:0]   data_q;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] low_cnt;

    logic          timeout_hit;
    logic          guard_clear;
    logic          guard_expired;
    logic          eval_fault;
    logic [7:0]    eval_code;
    logic [7:0]    eval_data;

    assign state_dbg   = state;
    assign timeout_hit = (tmo_cnt == TMO_LAST);
    // Clear on the very edge that leaves READ, so the guard starts with EVAL.
    assign guard_clear = (state == ST_READ) && (sensor_done || timeout_hit);

    dht11_guard_timer #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guard (
        .clock   (clock),
        .reset   (reset),
        .clear   (guard_clear),
        .expired (guard_expired)
    );

    always_comb begin
        eval_fault = err_q || timed_out || !checksum_ok(data_q);
        eval_code  = RSP_FAULT;
        eval_data  = 8'h00;
        if (!eval_fault) begin
            case (kind)
                KIND_TEMP: begin
                    eval_code = RSP_TEMP;
                    eval_data = data_q[23:16];
                end
                KIND_HUM: begin
                    eval_code = RSP_HUM;
                    eval_data = data_q[39:32];
                end
                default: begin
                    eval_code = RSP_OK;
                    eval_data = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_code     <= 8'h00;
            resp_data     <= 8'h00;
            sensor_enable <= 1'b0;
            cont_mode     <= 1'b0;
            kind          <= KIND_STATUS;
            timed_out     <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= '0;
            tmo_cnt       <= '0;
            low_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_needs_read(cmd_code)) begin
                            kind      <= cmd_kind(cmd_code);
                            cont_mode <= cmd_is_cont(cmd_code);
                            state     <= ST_GUARD;
                        end else begin
                            resp_code  <= (cmd_code == CMD_STOP) ? RSP_STOPPED : RSP_INVALID;
                            resp_data  <= 8'h00;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end

                ST_GUARD: begin
                    if (guard_expired) begin
                        low_cnt <= '0;
                        state   <= ST_LOW;
                    end
                end

                ST_LOW: begin
                    if (low_cnt == LOW_LAST) begin
                        sensor_enable <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= ST_READ;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                ST_READ: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (sensor_done) begin
                        sensor_enable <= 1'b0;
                        data_q        <= sensor_data;
                        err_q         <= sensor_error;
                        timed_out     <= 1'b0;
                        state         <= ST_EVAL;
                    end else if (timeout_hit) begin
                        sensor_enable <= 1'b0;
                        err_q         <= 1'b0;
                        timed_out     <= 1'b1;
                        state         <= ST_EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_EVAL: begin
                    resp_code  <= eval_code;
                    resp_data  <= eval_data;
                    resp_valid <= 1'b1;
                    if (eval_fault) begin
                        cont_mode <= 1'b0;
                    end
                    state <= ST_RESP;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= cont_mode ? ST_CONT_WAIT : ST_IDLE;
                    end
                end

                ST_CONT_WAIT: begin
                    // A command takes priority over starting the next periodic read.
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        resp_data  <= 8'h00;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                        if (cmd_code == CMD_STOP) begin
                            cont_mode <= 1'b0;
                            resp_code <= RSP_STOPPED;
                        end else begin
                            resp_code <= RSP_INVALID;
                        end
                    end else if (guard_expired) begin
                        cmd_ready <= 1'b0;
                        low_cnt   <= '0;
                        state     <= ST_LOW;
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    cmd_ready     <= 1'b1;
                    resp_valid    <= 1'b0;
                    sensor_enable <= 1'b0;
                    cont_mode     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Bench for dht11_read_scheduler: vector table, hand-written multi-cycle
// sequences and random commands against a behavioural response model.
`timescale 1ns/1ps
module tb_dht11_read_scheduler;
    import dht11_sched_pkg::*;

    localparam int GUARD = 50;
    localparam int TMO   = 200;
    localparam int LOWC  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_code = 4'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_code;
    logic [7:0]  resp_data;
    logic        sensor_enable;
    logic [39:0] sensor_data = '0;
    logic        sensor_error = 1'b0;
    logic        sensor_done = 1'b0;
    state_t      state_dbg;

    dht11_read_scheduler #(
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TMO),
        .LOW_CYCLES     (LOWC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_code      (cmd_code),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_code     (resp_code),
        .resp_data     (resp_data),
        .sensor_enable (sensor_enable),
        .sensor_data   (sensor_data),
        .sensor_error  (sensor_error),
        .sensor_done   (sensor_done),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int rst_cyc = 0;
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        rst_cyc = cyc;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- sensor block model ----------------
    logic [39:0] sens_value = '0;
    bit          sens_err   = 1'b0;
    bit          sens_never = 1'b0;
    int          sens_delay = 0;
    int          dly_left   = 0;
    int          rise_q[$];
    int          done_cyc   = 0;
    int          en_high    = 0;
    int          last_fall  = 0;
    bit          have_fall  = 1'b0;
    bit          en_prev    = 1'b0;

    always @(negedge clock) begin
        if (sensor_done && cyc == done_cyc + 1)
            check("enable_low_in_eval", sensor_enable, 1'b0);
        if (!sensor_enable && en_prev) begin
            last_fall = cyc;
            have_fall = 1'b1;
        end
        if (sensor_enable) begin
            if (!en_prev) begin
                rise_q.push_back(cyc);
                dly_left = sens_delay;
                en_high  = 0;
            end
            en_high++;
            if (!sens_never && !sensor_done) begin
                if (dly_left == 0) begin
                    sensor_data  = sens_value;
                    sensor_error = sens_err;
                    sensor_done  = 1'b1;
                    done_cyc     = cyc;
                end else begin
                    dly_left--;
                end
            end
        end else begin
            sensor_done  = 1'b0;
            sensor_error = 1'b0;
            sensor_data  = '0;
        end
        en_prev = sensor_enable;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_resp(input logic [3:0] c, input logic [39:0] d,
                                               input bit err, input bit tmo);
        int sum;
        if (c > 4'h5) return {8'hFF, 8'h00};
        if (c == 4'h5) return {8'h0A, 8'h00};
        sum = (int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8])) % 256;
        if (err || tmo || sum != int'(d[7:0])) return {8'h1F, 8'h00};
        if (c == 4'h0) return {8'h07, 8'h00};
        if (c == 4'h1 || c == 4'h3) return {8'h09, d[23:16]};
        return {8'h08, d[39:32]};
    endfunction

    // ---------------- driver tasks (called at a falling edge) ----------------
    int cmd_cyc = 0;
    task automatic send_cmd(input logic [3:0] code);
        int n;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_cyc   = cyc;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_code  = 4'h0;
    endtask

    task automatic get_resp(input int budget, input int stall,
                            output logic [7:0] code, output logic [7:0] data, output int seen);
        int n;
        n = 0;
        while (!resp_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("resp_wait", resp_valid, 1'b1);
        code = resp_code;
        data = resp_data;
        seen = cyc;
        repeat (stall) @(negedge clock);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One non-continuous command with full checking of result and timing.
    task automatic do_txn(input string tag, input logic [3:0] c, input logic [39:0] v,
                          input bit e, input bit nv, input int stall,
                          input logic [7:0] exp_code, input logic [7:0] exp_data);
        logic [7:0] code, data;
        int seen, rises0, prev_fall;
        bit is_read, had_fall;
        is_read    = (c <= 4'h4);
        sens_value = v;
        sens_err   = e;
        sens_never = nv;
        sens_delay = $urandom_range(0, 25);
        rises0     = rise_q.size();
        prev_fall  = last_fall;
        had_fall   = have_fall;
        send_cmd(c);
        get_resp(TMO + 4 * GUARD, stall, code, data, seen);
        check({tag, "_code"}, code, exp_code);
        check({tag, "_data"}, data, exp_data);
        if (!is_read) begin
            check({tag, "_cmd_latency"}, seen - cmd_cyc, 1);
            check({tag, "_no_read"}, rise_q.size(), rises0);
        end else begin
            check({tag, "_one_read"}, rise_q.size(), rises0 + 1);
            if (had_fall)
                check({tag, "_guard_gap"}, (rise_q[$] - prev_fall) >= (GUARD + LOWC), 1'b1);
            if (nv) check({tag, "_tmo_cycles"}, en_high, TMO);
            else    check({tag, "_done_latency"}, seen - done_cyc, 2);
        end
        sens_never = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  cmd;
        logic [39:0] value;
        bit          err;
        bit          never;
        logic [7:0]  code;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0]  code, data;
        logic [39:0] v;
        logic [3:0]  c;
        logic [15:0] exp;
        int seen, r, ck, n, nvalid;
        bit e;

        vecs[0]  = '{4'h1, 40'h320019004B, 1'b0, 1'b0, 8'h09, 8'h19};
        vecs[1]  = '{4'h2, 40'h3200190064, 1'b0, 1'b0, 8'h1F, 8'h00};
        vecs[2]  = '{4'h0, 40'h3200190063, 1'b0, 1'b0, 8'h1F, 8'h00};
        vecs[3]  = '{4'h0, 40'h1E05140239, 1'b0, 1'b0, 8'h07, 8'h00};
        vecs[4]  = '{4'h2, 40'h1E05140239, 1'b0, 1'b0, 8'h08, 8'h1E};
        vecs[5]  = '{4'h1, 40'h1E05140239, 1'b1, 1'b0, 8'h1F, 8'h00};
        vecs[6]  = '{4'h1, 40'hFFFF010201, 1'b0, 1'b0, 8'h09, 8'h01};
        vecs[7]  = '{4'h0, 40'h1E05140239, 1'b0, 1'b1, 8'h1F, 8'h00};
        vecs[8]  = '{4'h7, 40'h0000000000, 1'b0, 1'b0, 8'hFF, 8'h00};
        vecs[9]  = '{4'h5, 40'h0000000000, 1'b0, 1'b0, 8'h0A, 8'h00};
        vecs[10] = '{4'hF, 40'h0000000000, 1'b0, 1'b0, 8'hFF, 8'h00};
        vecs[11] = '{4'h6, 40'h0000000000, 1'b0, 1'b0, 8'hFF, 8'h00};

        @(negedge clock);
        do_reset();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_code", resp_code, 8'h00);
        check("rst_resp_data", resp_data, 8'h00);
        check("rst_sensor_enable", sensor_enable, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);

        rise_q.delete();
        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].value, vecs[i].err,
                   vecs[i].never, 0, vecs[i].code, vecs[i].data);
            if (i == 0)
                check("first_rise_after_reset", (rise_q[0] - rst_cyc) >= (GUARD + LOWC), 1'b1);
        end

        // invalid command with the response held off for ten cycles
        send_cmd(4'h7);
        check("stall_latency", resp_valid, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", resp_valid, 1'b1);
            check("stall_code", resp_code, 8'hFF);
            check("stall_data", resp_data, 8'h00);
            @(negedge clock);
        end
        get_resp(5, 0, code, data, seen);

        // continuous humidity, a foreign command in between, then stop
        rise_q.delete();
        sens_value = 40'h2D00170044;
        sens_err   = 1'b0;
        sens_delay = 5;
        send_cmd(4'h4);
        get_resp(1000, 0, code, data, seen);
        check("cont1_code", code, 8'h08);
        check("cont1_data", data, 8'h2D);
        send_cmd(4'h1);
        get_resp(1000, 0, code, data, seen);
        check("cont_foreign_code", code, 8'hFF);
        check("cont_foreign_latency", seen - cmd_cyc, 1);
        get_resp(1000, 0, code, data, seen);
        check("cont2_code", code, 8'h08);
        get_resp(1000, 1, code, data, seen);
        check("cont3_code", code, 8'h08);
        check("cont3_data", data, 8'h2D);
        send_cmd(4'h5);
        get_resp(1000, 0, code, data, seen);
        check("cont_stop_code", code, 8'h0A);
        idle(150);
        check("cont_rise_count", rise_q.size(), 3);
        for (int k = 1; k < rise_q.size(); k++)
            check("cont_rise_spacing", (rise_q[k] - rise_q[k-1]) >= (GUARD + LOWC), 1'b1);
        check("cont_stop_ready", cmd_ready, 1'b1);

        // a faulted read ends continuous temperature mode
        rise_q.delete();
        sens_err = 1'b1;
        send_cmd(4'h3);
        get_resp(1000, 0, code, data, seen);
        check("cont_fault_code", code, 8'h1F);
        check("cont_fault_data", data, 8'h00);
        idle(150);
        check("cont_fault_rises", rise_q.size(), 1);
        check("cont_fault_ready", cmd_ready, 1'b1);
        sens_err = 1'b0;

        // random one-shot commands against the model
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       c = 4'(r % 3);
            else if (r == 6) c = 4'h5;
            else             c = 4'($urandom_range(6, 15));
            v[39:8] = $urandom();
            ck = (int'(v[39:32]) + int'(v[31:24]) + int'(v[23:16]) + int'(v[15:8])) % 256;
            v[7:0] = ($urandom_range(0, 3) != 0) ? 8'(ck) : 8'($urandom());
            e = ($urandom_range(0, 7) == 0);
            exp = model_resp(c, v, e, 1'b0);
            do_txn($sformatf("rand%0d", i), c, v, e, 1'b0, $urandom_range(0, 3),
                   exp[15:8], exp[7:0]);
        end

        // reset pulsed in the middle of a read
        sens_never = 1'b1;
        send_cmd(4'h1);
        n = 0;
        while (!sensor_enable && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("rst_read_started", sensor_enable, 1'b1);
        idle(5);
        reset = 1'b1;
        @(negedge clock);
        check("rst_enable_drop", sensor_enable, 1'b0);
        reset = 1'b0;
        nvalid = 0;
        repeat (100) begin
            @(negedge clock);
            if (resp_valid) nvalid++;
        end
        check("rst_no_resp", nvalid, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1'b1);
        sens_never = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
